mem_port_arbiter: RTL and testbench

- Shares the single-port 32x8 unified instruction/data memory of the 8-bit accumulator-style core between three requesters:
  - host loader (port 0)
  - core data LD/ST (port 1)
  - core instruction fetch (port 2)
- Round-robin arbitration with a req/gnt handshake.
- One access is issued per cycle. Read data returns one cycle after grant.
- Sits between the core/loader and the memory array; the memory becomes a plain synchronous-read RAM.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 30 +++
 rtl/mem_port_arbiter_rr_pick3.sv | 31 +++
 rtl/mem_port_arbiter.sv | 84 ++++++++
 tb/tb_mem_port_arbiter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-memory port arbiter: widths, port indices
// and the round-robin pointer advance.
package mem_port_arbiter_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int NREQ   = 3;

  localparam int PORT_HOST  = 0;
  localparam int PORT_DATA  = 1;
  localparam int PORT_FETCH = 2;

  function automatic logic [1:0] next_ptr(input logic [1:0] win);
    return (win == 2'd2) ? 2'd0 : win + 2'd1;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter; slave = arbiter,
// master = the requesters plus the RAM.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic                   host_lock;
  logic                   core_stall;
  logic                   mem_en;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req, we, addr, wdata, host_lock, mem_rdata,
    output gnt, rvalid, rdata, core_stall, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, we, addr, wdata, host_lock, mem_rdata,
    input  gnt, rvalid, rdata, core_stall, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: first requester at or after ptr wins.
module rr_pick3 (
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_gnt,
  output logic [1:0] o_win,
  output logic       o_any
);
  logic [1:0] w_order [3];

  always_comb begin
    case (i_ptr)
      2'd1:    begin w_order[0] = 2'd1; w_order[1] = 2'd2; w_order[2] = 2'd0; end
      2'd2:    begin w_order[0] = 2'd2; w_order[1] = 2'd0; w_order[2] = 2'd1; end
      default: begin w_order[0] = 2'd0; w_order[1] = 2'd1; w_order[2] = 2'd2; end
    endcase
  end

  always_comb begin
    o_gnt = '0;
    o_win = '0;
    o_any = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!o_any && i_req[w_order[k]]) begin
        o_any            = 1'b1;
        o_win            = w_order[k];
        o_gnt[w_order[k]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM between host, data and
// fetch ports. Optional host lock: define ARB_HOST_LOCK_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  logic [NREQ-1:0] w_req_eff;
  logic [NREQ-1:0] w_pick;
  logic [NREQ-1:0] w_gnt;
  logic [1:0]      w_win;
  logic            w_any;
  logic            w_hold_ptr;
  logic [1:0]      r_rr_ptr;
  logic [NREQ-1:0] r_rvalid;

`ifdef ARB_HOST_LOCK_EN
  logic r_lock;

  // While locked only the host may compete; the pointer is frozen.
  always_comb begin
    w_req_eff = bus.req;
    if (r_lock) begin
      w_req_eff[PORT_DATA]  = 1'b0;
      w_req_eff[PORT_FETCH] = 1'b0;
    end
  end
  assign w_hold_ptr = r_lock;

  always_ff @(posedge clk) begin
    if (rst)         r_lock <= 1'b0;
    else if (r_lock) r_lock <= bus.host_lock;
    else             r_lock <= bus.host_lock & w_gnt[PORT_HOST];
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = bus.host_lock;
  assign w_req_eff     = bus.req;
  assign w_hold_ptr    = 1'b0;
`endif

  rr_pick3 u_pick (
    .i_req (w_req_eff),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick),
    .o_win (w_win),
    .o_any (w_any)
  );

  assign w_gnt = rst ? '0 : w_pick;

  always_comb begin
    bus.mem_en    = |w_gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        bus.mem_we    = bus.we[i];
        bus.mem_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        bus.mem_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 2'd0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= w_gnt & ~bus.we;
      if (w_any && !w_hold_ptr) r_rr_ptr <= next_ptr(w_win);
    end
  end

  // Gating rvalid with rst drops a read whose data would land during reset.
  assign bus.gnt        = w_gnt;
  assign bus.rvalid     = rst ? '0 : r_rvalid;
  assign bus.rdata      = rst ? '0 : bus.mem_rdata;
  assign bus.core_stall = ~rst & ((bus.req[PORT_DATA]  & ~w_gnt[PORT_DATA]) |
                                  (bus.req[PORT_FETCH] & ~w_gnt[PORT_FETCH]));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural sync-read RAM.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] mem [32];

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic [2:0] r, input logic [2:0] w,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic hl);
    @(negedge clk);
    rst            = rs;
    bus.req        = r;
    bus.we         = w;
    bus.addr       = {a2, a1, a0};
    bus.wdata      = {d2, d1, d0};
    bus.host_lock  = hl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 8'h0, 8'h0, 8'h0, 1'b0);
  endtask

  logic [2:0] rr_exp [6];
  logic [2:0] lk_exp [6];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[5] = 8'h3C;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    bus.host_lock = 1'b0; bus.mem_rdata = '0;
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`ifdef ARB_HOST_LOCK_EN
    lk_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010};
`else
    lk_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif

    // reset with everyone requesting: all outputs held low
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 3'b111, 3'b000, 5'd0, 5'd1, 5'd2, 8'h0, 8'h0, 8'h0, 1'b0);
      chk("rst_gnt", bus.gnt, 3'b000);
      chk("rst_mem_en", bus.mem_en, 1'b0);
      chk("rst_stall", bus.core_stall, 1'b0);
      chk("rst_rvalid", bus.rvalid, 3'b000);
    end

    // single fetch read of addr 5
    drive(1'b0, 3'b100, 3'b000, 5'd0, 5'd0, 5'd5, 8'h0, 8'h0, 8'h0, 1'b0);
    chk("rd1_gnt", bus.gnt, 3'b100);
    chk("rd1_mem_en", bus.mem_en, 1'b1);
    chk("rd1_mem_we", bus.mem_we, 1'b0);
    chk("rd1_mem_addr", bus.mem_addr, 5'd5);
    chk("rd1_stall", bus.core_stall, 1'b0);
    idle();
    chk("rd1_rvalid", bus.rvalid, 3'b100);
    chk("rd1_rdata", bus.rdata, 8'h3C);
    chk("rd1_idle_gnt", bus.gnt, 3'b000);
    chk("rd1_idle_en", bus.mem_en, 1'b0);

    // all three requesting continuously: 0,1,2,0,1,2
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 3'b111, 3'b000, 5'd0, 5'd1, 5'd2, 8'h0, 8'h0, 8'h0, 1'b0);
      chk("rr_gnt", bus.gnt, rr_exp[c]);
      chk("rr_stall", bus.core_stall, 1'b1);
      chk("rr_rvalid", bus.rvalid, (c == 0) ? 3'b000 : rr_exp[c-1]);
      if (c > 0) chk("rr_rdata", bus.rdata, (c % 3 == 1) ? 8'h11 : (c % 3 == 2) ? 8'h22 : 8'h33);
    end
    idle();
    chk("rr_last_rvalid", bus.rvalid, 3'b100);
    chk("rr_last_rdata", bus.rdata, 8'h33);

    // port 1 writes, port 2 reads it back next cycle
    drive(1'b0, 3'b010, 3'b010, 5'd0, 5'h10, 5'd0, 8'h0, 8'hA5, 8'h0, 1'b0);
    chk("wr_gnt", bus.gnt, 3'b010);
    chk("wr_mem_we", bus.mem_we, 1'b1);
    chk("wr_mem_addr", bus.mem_addr, 5'h10);
    chk("wr_mem_wdata", bus.mem_wdata, 8'hA5);
    drive(1'b0, 3'b100, 3'b000, 5'd0, 5'd0, 5'h10, 8'h0, 8'h0, 8'h0, 1'b0);
    chk("wr_rd_gnt", bus.gnt, 3'b100);
    chk("wr_no_rvalid", bus.rvalid, 3'b000);
    idle();
    chk("wr_rd_rvalid", bus.rvalid, 3'b100);
    chk("wr_rd_rdata", bus.rdata, 8'hA5);

    // back-to-back fetch reads, no bubble
    drive(1'b0, 3'b100, 3'b000, 5'd0, 5'd0, 5'd0, 8'h0, 8'h0, 8'h0, 1'b0);
    chk("b2b_gnt0", bus.gnt, 3'b100);
    drive(1'b0, 3'b100, 3'b000, 5'd0, 5'd0, 5'd1, 8'h0, 8'h0, 8'h0, 1'b0);
    chk("b2b_gnt1", bus.gnt, 3'b100);
    chk("b2b_rvalid0", bus.rvalid, 3'b100);
    chk("b2b_rdata0", bus.rdata, 8'h11);
    idle();
    chk("b2b_rvalid1", bus.rvalid, 3'b100);
    chk("b2b_rdata1", bus.rdata, 8'h22);

    // reset right after a host read grant: read is lost, pointer back to 0
    drive(1'b0, 3'b001, 3'b000, 5'd1, 5'd0, 5'd0, 8'h0, 8'h0, 8'h0, 1'b0);
    chk("mrst_gnt", bus.gnt, 3'b001);
    drive(1'b1, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 8'h0, 8'h0, 8'h0, 1'b0);
    chk("mrst_rvalid_rst", bus.rvalid, 3'b000);
    drive(1'b0, 3'b111, 3'b000, 5'd1, 5'd1, 5'd1, 8'h0, 8'h0, 8'h0, 1'b0);
    chk("mrst_rvalid_after", bus.rvalid, 3'b000);
    chk("mrst_ptr0_gnt", bus.gnt, 3'b001);
    idle();
    chk("mrst_next_rvalid", bus.rvalid, 3'b001);
    chk("mrst_next_rdata", bus.rdata, 8'h22);

    // park pointer at 0, then host writes 4 bytes holding host_lock
    drive(1'b0, 3'b100, 3'b000, 5'd0, 5'd0, 5'd0, 8'h0, 8'h0, 8'h0, 1'b0);
    chk("park_gnt", bus.gnt, 3'b100);
    for (int c = 0; c < 6; c++) begin
      if (c < 4)
        drive(1'b0, 3'b111, 3'b001, 5'(5'h18 + c), 5'd0, 5'd0, 8'(8'hC0 + c), 8'h0, 8'h0, 1'b1);
      else
        drive(1'b0, 3'b110, 3'b000, 5'd0, 5'd0, 5'd0, 8'h0, 8'h0, 8'h0, 1'b0);
      chk("lock_gnt", bus.gnt, lk_exp[c]);
      chk("lock_stall", bus.core_stall, 1'b1);
    end
    drive(1'b0, 3'b100, 3'b000, 5'd0, 5'd0, 5'h18, 8'h0, 8'h0, 8'h0, 1'b0);
    chk("lock_rb_gnt", bus.gnt, 3'b100);
    idle();
    chk("lock_rb_rvalid", bus.rvalid, 3'b100);
    chk("lock_rb_rdata", bus.rdata, 8'hC0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
